// File: rtl/onehot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_seq_pkg
// Description : Shared run-mode encoding and index-width helper for the
//               one-hot sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_seq_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage : onehot_seq_pkg
`default_nettype wire

// File: rtl/onehot_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : onehot_to_bin
// Description : One-hot to binary index converter with an invalid-code flag.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_bin
    import onehot_seq_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int IDX_W      = idx_width(NUM_STATES)
) (
    input  logic [NUM_STATES-1:0] onehot_i,
    output logic [IDX_W-1:0]      bin_o,
    output logic                  invalid_o
);

    // OR of set-bit positions; only meaningful when invalid_o is low.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (onehot_i[i]) begin
                bin_o = bin_o | IDX_W'(i);
            end
        end
    end

    assign invalid_o = (onehot_i == '0) ||
                       ((onehot_i & (onehot_i - NUM_STATES'(1))) != '0);

endmodule : onehot_to_bin
`default_nettype wire

// File: rtl/onehot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : onehot_sequencer
// Description : One-hot state sequencer with programmable dwell and
//               wrap / one-shot / bounce run modes, plus illegal-state repair.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_sequencer
    import onehot_seq_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int DWELL_W    = 4,
    localparam int IDX_W     = idx_width(NUM_STATES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  dir,
    input  logic                  start,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [NUM_STATES-1:0] state,
    output logic [IDX_W-1:0]      idx,
    output logic                  wrap,
    output logic                  busy,
    output logic                  err
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_STATES - 1);

    logic [NUM_STATES-1:0] state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  up_q, up_d;

    logic [NUM_STATES-1:0] w_cur_state;
    logic [IDX_W-1:0]      w_cur_idx;
    logic                  w_invalid;
    mode_e                 w_mode;

    assign w_cur_state = state_q;
    assign w_mode      = mode_e'(mode);

    onehot_to_bin #(
        .NUM_STATES (NUM_STATES),
        .IDX_W      (IDX_W)
    ) u_dec (
        .onehot_i  (w_cur_state),
        .bin_o     (w_cur_idx),
        .invalid_o (w_invalid)
    );

    always_comb begin
        idx_d  = w_cur_idx;
        cnt_d  = cnt_q;
        up_d   = up_q;
        busy_d = busy_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;

        if (w_invalid) begin
            idx_d = '0;
            cnt_d = '0;
            err_d = 1'b1;
        end else if (en) begin
            // One-shot idles only at index 0; a run entered elsewhere finishes first.
            if (w_mode == MODE_ONESHOT && !busy_q && w_cur_idx == '0) begin
                cnt_d = '0;
                if (start) begin
                    busy_d = 1'b1;
                end
            end else if (cnt_q >= dwell) begin
                cnt_d = '0;
                case (w_mode)
                    MODE_ONESHOT: begin
                        if (w_cur_idx == c_last_idx) begin
                            idx_d  = '0;
                            busy_d = 1'b0;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = w_cur_idx + IDX_W'(1);
                        end
                    end
                    MODE_BOUNCE: begin
                        busy_d = 1'b0;
                        if ((up_q && w_cur_idx != c_last_idx) || w_cur_idx == '0) begin
                            idx_d = w_cur_idx + IDX_W'(1);
                        end else begin
                            idx_d = w_cur_idx - IDX_W'(1);
                        end
                        if (idx_d == c_last_idx) begin
                            up_d   = 1'b0;
                            wrap_d = 1'b1;
                        end else if (idx_d == '0) begin
                            up_d   = 1'b1;
                            wrap_d = 1'b1;
                        end
                    end
                    default: begin
                        busy_d = 1'b0;
                        if (!dir) begin
                            if (w_cur_idx == c_last_idx) begin
                                idx_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                idx_d = w_cur_idx + IDX_W'(1);
                            end
                        end else begin
                            if (w_cur_idx == '0) begin
                                idx_d  = c_last_idx;
                                wrap_d = 1'b1;
                            end else begin
                                idx_d = w_cur_idx - IDX_W'(1);
                            end
                        end
                    end
                endcase
            end else begin
                cnt_d = cnt_q + DWELL_W'(1);
            end
        end

        state_d = NUM_STATES'(1) << idx_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NUM_STATES'(1);
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            up_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            up_q    <= up_d;
        end
    end

    assign state = state_q;
    assign idx   = idx_q;
    assign wrap  = wrap_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule : onehot_sequencer
`default_nettype wire

// File: tb/tb_onehot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_sequencer
// Description : Directed self-checking bench for onehot_sequencer (N=4,5,2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       dir = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dwell = 4'd0;

    logic [3:0] s4;  logic [1:0] i4; logic w4, b4, e4;
    logic [4:0] s5;  logic [2:0] i5; logic w5, b5, e5;
    logic [1:0] s2;  logic [0:0] i2; logic w2, b2, e2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    onehot_sequencer #(.NUM_STATES(4), .DWELL_W(4)) u4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .start(start),
        .dwell(dwell), .state(s4), .idx(i4), .wrap(w4), .busy(b4), .err(e4));
    onehot_sequencer #(.NUM_STATES(5), .DWELL_W(4)) u5 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .start(start),
        .dwell(dwell), .state(s5), .idx(i5), .wrap(w5), .busy(b5), .err(e5));
    onehot_sequencer #(.NUM_STATES(2), .DWELL_W(4)) u2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir), .start(start),
        .dwell(dwell), .state(s2), .idx(i2), .wrap(w2), .busy(b2), .err(e2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        mode = 2'b00; dir = 1'b0; dwell = 4'd0; en = 1'b1; start = 1'b0;
        apply_reset();
        vectors++;
        if (s4 !== 4'b0001 || i4 !== 2'd0 || w4 !== 1'b0 || b4 !== 1'b0 || e4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: state=%b idx=%0d wrap=%b busy=%b err=%b, want 0001/0/0/0/0",
                     s4, i4, w4, b4, e4);
        end
    endtask

    task automatic test_wrap_up;
        int e_idx [4] = '{1, 2, 3, 0};
        bit e_wr  [4] = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (s4 !== 4'(1 << e_idx[i]) || i4 !== 2'(e_idx[i]) || w4 !== e_wr[i]) begin
                miscompares++;
                $display("FAIL wrap_up step %0d: state=%b idx=%0d wrap=%b, want idx=%0d wrap=%0d",
                         i, s4, i4, w4, e_idx[i], e_wr[i]);
            end
        end
    endtask

    task automatic test_wrap_down_freeze;
        int e_idx [15] = '{0, 0, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3};
        bit e_wr  [15] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        int f_idx [6]  = '{0, 0, 3, 3, 3, 2};
        bit f_wr  [6]  = '{0, 0, 1, 0, 0, 0};
        mode = 2'b00; dir = 1'b1; dwell = 4'd2; en = 1'b1;
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++;
            if (s4 !== 4'(1 << e_idx[i]) || i4 !== 2'(e_idx[i]) || w4 !== e_wr[i]) begin
                miscompares++;
                $display("FAIL wrap_down step %0d: state=%b idx=%0d wrap=%b, want idx=%0d wrap=%0d",
                         i, s4, i4, w4, e_idx[i], e_wr[i]);
            end
        end
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (i4 !== 2'(f_idx[i]) || w4 !== f_wr[i]) begin
                miscompares++;
                $display("FAIL freeze_pre step %0d: idx=%0d wrap=%b, want idx=%0d wrap=%0d",
                         i, i4, w4, f_idx[i], f_wr[i]);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (s4 !== 4'b1000 || i4 !== 2'd3 || w4 !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze hold %0d: state=%b idx=%0d wrap=%b, want 1000/3/0",
                         i, s4, i4, w4);
            end
        end
        en = 1'b1;
        for (int i = 4; i < 6; i++) begin
            tick();
            vectors++;
            if (i4 !== 2'(f_idx[i]) || w4 !== f_wr[i]) begin
                miscompares++;
                $display("FAIL freeze_post step %0d: idx=%0d wrap=%b, want idx=%0d wrap=%0d",
                         i, i4, w4, f_idx[i], f_wr[i]);
            end
        end
    endtask

    task automatic test_oneshot;
        int e_idx [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
        mode = 2'b01; dir = 1'b0; dwell = 4'd1; en = 1'b1; start = 1'b0;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (s5 !== 5'b00001 || b5 !== 1'b0 || w5 !== 1'b0) begin
                miscompares++;
                $display("FAIL oneshot idle %0d: state=%b busy=%b wrap=%b, want 00001/0/0",
                         i, s5, b5, w5);
            end
        end
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (s5 !== 5'(1 << e_idx[i]) || i5 !== 3'(e_idx[i]) || b5 !== 1'b1 || w5 !== 1'b0) begin
                miscompares++;
                $display("FAIL oneshot run %0d: state=%b idx=%0d busy=%b wrap=%b, want idx=%0d busy=1 wrap=0",
                         i, s5, i5, b5, w5, e_idx[i]);
            end
            start = (i == 3);
        end
        tick();
        vectors++;
        if (s5 !== 5'b00001 || i5 !== 3'd0 || b5 !== 1'b0 || w5 !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot end: state=%b idx=%0d busy=%b wrap=%b, want 00001/0/0/1",
                     s5, i5, b5, w5);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (s5 !== 5'b00001 || b5 !== 1'b0 || w5 !== 1'b0) begin
                miscompares++;
                $display("FAIL oneshot after %0d: state=%b busy=%b wrap=%b, want 00001/0/0",
                         i, s5, b5, w5);
            end
        end
    endtask

    task automatic test_bounce;
        int e_idx [7] = '{1, 2, 3, 2, 1, 0, 1};
        bit e_wr  [7] = '{0, 0, 1, 0, 0, 1, 0};
        mode = 2'b10; dir = 1'b0; dwell = 4'd0; en = 1'b1;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            vectors++;
            if (s4 !== 4'(1 << e_idx[i]) || i4 !== 2'(e_idx[i]) || w4 !== e_wr[i]) begin
                miscompares++;
                $display("FAIL bounce4 step %0d: state=%b idx=%0d wrap=%b, want idx=%0d wrap=%0d",
                         i, s4, i4, w4, e_idx[i], e_wr[i]);
            end
            vectors++;
            if (s2 !== 2'(1 << ((i + 1) % 2)) || i2 !== 1'((i + 1) % 2) || w2 !== 1'b1) begin
                miscompares++;
                $display("FAIL bounce2 step %0d: state=%b idx=%0d wrap=%b, want idx=%0d wrap=1",
                         i, s2, i2, w2, (i + 1) % 2);
            end
        end
    endtask

    task automatic test_illegal;
        mode = 2'b00; dir = 1'b0; dwell = 4'd0; en = 1'b1;
        apply_reset();
        tick();
        force u4.w_cur_state = 4'b0110;
        tick();
        release u4.w_cur_state;
        vectors++;
        if (s4 !== 4'b0001 || i4 !== 2'd0 || e4 !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_0110 fix: state=%b idx=%0d err=%b, want 0001/0/1", s4, i4, e4);
        end
        tick();
        vectors++;
        if (s4 !== 4'b0010 || i4 !== 2'd1 || e4 !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_0110 resume: state=%b idx=%0d err=%b, want 0010/1/0", s4, i4, e4);
        end
        en = 1'b0;
        force u4.w_cur_state = 4'b0000;
        tick();
        release u4.w_cur_state;
        vectors++;
        if (s4 !== 4'b0001 || i4 !== 2'd0 || e4 !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_0000 fix: state=%b idx=%0d err=%b, want 0001/0/1", s4, i4, e4);
        end
        tick();
        vectors++;
        if (s4 !== 4'b0001 || e4 !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_0000 hold: state=%b err=%b, want 0001/0", s4, e4);
        end
        en = 1'b1;
        tick();
        vectors++;
        if (s4 !== 4'b0010 || i4 !== 2'd1 || e4 !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_0000 resume: state=%b idx=%0d err=%b, want 0010/1/0", s4, i4, e4);
        end
    endtask

    task automatic test_reset_midrun;
        mode = 2'b01; dir = 1'b0; dwell = 4'd0; en = 1'b1;
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (i4 !== 2'd2 || b4 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun pre: idx=%0d busy=%b, want 2/1", i4, b4);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (s4 !== 4'b0001 || i4 !== 2'd0 || b4 !== 1'b0 || w4 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun reset: state=%b idx=%0d busy=%b wrap=%b, want 0001/0/0/0",
                     s4, i4, b4, w4);
        end
    endtask

    task automatic test_mode_change;
        int a_idx [9] = '{0, 0, 3, 3, 3, 2, 2, 2, 1};
        int b_idx [6] = '{1, 1, 2, 2, 2, 3};
        bit b_wr  [6] = '{0, 0, 0, 0, 0, 1};
        mode = 2'b00; dir = 1'b1; dwell = 4'd2; en = 1'b1;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            tick();
            vectors++;
            if (i4 !== 2'(a_idx[i])) begin
                miscompares++;
                $display("FAIL modechg pre %0d: idx=%0d, want %0d", i, i4, a_idx[i]);
            end
        end
        mode = 2'b10;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (i4 !== 2'(b_idx[i]) || w4 !== b_wr[i]) begin
                miscompares++;
                $display("FAIL modechg post %0d: idx=%0d wrap=%b, want idx=%0d wrap=%0d",
                         i, i4, w4, b_idx[i], b_wr[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down_freeze();
        test_oneshot();
        test_bounce();
        test_illegal();
        test_reset_midrun();
        test_mode_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule : tb_onehot_sequencer
`default_nettype wire
